// File: rtl/alu_result_stage_if.sv
// Result-stage bus: ALU result and key levels in, held/display values out.
// slave = the result stage, master = the ALU/board side driving it.
interface alu_result_stage_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] alu_in;
  logic [2:0]       func;
  logic             load;
  logic             recall;
  logic [WIDTH-1:0] q;
  logic [3:0]       b_fb;
  logic [WIDTH-1:0] disp;
  logic             recall_active;
  logic [CW-1:0]    count;
  logic             ovf;

  modport slave (
    input  alu_in, func, load, recall,
    output q, b_fb, disp, recall_active,
    output count, ovf
  );

  modport master (
    output alu_in, func, load, recall,
    input  q, b_fb, disp, recall_active,
    input  count, ovf
  );
endinterface

// File: rtl/alu_result_stage.sv
// Result register + DEPTH-entry history with recall view and idle timeout.
// Ports: clock, resetn (async low), io (slave): alu_in/func/load/recall in;
// q/b_fb/disp/recall_active/count/ovf out. Optional ALU_RESULT_STAGE_OVF_EN.
module alu_result_stage #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic              clock,
  input  logic              resetn,
  alu_result_stage_if.slave io
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {LIVE, RECALL} state_t;

  logic [1:0] load_sync;
  logic [1:0] recall_sync;
  logic       load_prev;
  logic       recall_prev;
  logic       load_press;
  logic       recall_press;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] hist [DEPTH];
  logic [CW-1:0]    count_r;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          idx_last;
  logic          tmr_done;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      load_sync   <= '0;
      recall_sync <= '0;
      load_prev   <= 1'b0;
      recall_prev <= 1'b0;
    end else begin
      load_sync   <= {load_sync[0], io.load};
      recall_sync <= {recall_sync[0], io.recall};
      load_prev   <= load_sync[1];
      recall_prev <= recall_sync[1];
    end
  end

  assign load_press   = load_sync[1] & ~load_prev;
  assign recall_press = recall_sync[1] & ~recall_prev;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q_r     <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (load_press) begin
      q_r     <= io.alu_in;
      hist[0] <= q_r;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
      if (count_r != CW'(DEPTH)) count_r <= count_r + CW'(1);
    end
  end

  assign idx_last = (CW'(idx_q) + CW'(1)) == count_r;
  assign tmr_done = tmr_q == TW'(TIMEOUT - 1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= LIVE;
      idx_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
    end
  end

  // A capture always wins and drops any same-cycle recall press.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    if (load_press) begin
      state_d = LIVE;
      idx_d   = '0;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        LIVE: begin
          if (recall_press && count_r != '0) begin
            state_d = RECALL;
            idx_d   = '0;
            tmr_d   = '0;
          end
        end
        RECALL: begin
          unique case (1'b1)
            recall_press && idx_last: begin
              state_d = LIVE;
              idx_d   = '0;
              tmr_d   = '0;
            end
            recall_press && !idx_last: begin
              idx_d = idx_q + IW'(1);
              tmr_d = '0;
            end
            !recall_press && tmr_done: begin
              state_d = LIVE;
              idx_d   = '0;
              tmr_d   = '0;
            end
            default: tmr_d = tmr_q + TW'(1);
          endcase
        end
        default: begin
          state_d = LIVE;
          idx_d   = '0;
          tmr_d   = '0;
        end
      endcase
    end
  end

  assign io.q             = q_r;
  assign io.b_fb          = q_r[3:0];
  assign io.count         = count_r;
  assign io.recall_active = (state_q == RECALL);
  assign io.disp          = (state_q == RECALL) ? hist[idx_q] : q_r;

`ifdef ALU_RESULT_STAGE_OVF_EN
  logic ovf_r;
  // Adder-class functions: bit 4 of the result is the carry out.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) ovf_r <= 1'b0;
    else if (load_press && io.func inside {3'b000, 3'b001, 3'b010}
             && io.alu_in[4])
      ovf_r <= 1'b1;
  end
  assign io.ovf = ovf_r;
`else
  logic unused_func;
  assign unused_func = ^io.func;
  assign io.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (TIMEOUT=16).
// Each task drives one scenario and checks outputs inline.
module tb_alu_result_stage;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_result_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  alu_result_stage #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clock (clk),
    .resetn(resetn),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    bus.load = 1'b0;
    bus.recall = 1'b0;
    bus.alu_in = '0;
    bus.func = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_keys();
    @(negedge clk);
    bus.load = 1'b0;
    bus.recall = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic press_load(input logic [7:0] v, input logic [2:0] f);
    @(negedge clk);
    bus.alu_in = v;
    bus.func = f;
    bus.load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [7:0] v);
    press_load(v, 3'b011);
    release_keys();
  endtask

  task automatic press_recall();
    @(negedge clk);
    bus.recall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.q !== 8'h00 || bus.disp !== 8'h00 || bus.b_fb !== 4'h0 ||
        bus.recall_active !== 1'b0 || bus.count !== 3'd0 ||
        bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: q=%h disp=%h b_fb=%h ra=%b cnt=%0d ovf=%b want all 0",
               bus.q, bus.disp, bus.b_fb, bus.recall_active, bus.count, bus.ovf);
    end
  endtask

  task automatic test_basic_capture();
    @(negedge clk);
    bus.alu_in = 8'h13;
    bus.load = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.q !== 8'h00) begin
      errors++;
      $display("FAIL cap_early: q=%h want 00", bus.q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.q !== 8'h13 || bus.disp !== 8'h13 || bus.b_fb !== 4'h3 ||
        bus.count !== 3'd1) begin
      errors++;
      $display("FAIL cap: q=%h disp=%h b_fb=%h cnt=%0d want 13 13 3 1",
               bus.q, bus.disp, bus.b_fb, bus.count);
    end
    release_keys();
    press_recall();
    checks++;
    if (bus.disp !== 8'h00 || bus.recall_active !== 1'b1) begin
      errors++;
      $display("FAIL cap_hist0: disp=%h ra=%b want 00 1",
               bus.disp, bus.recall_active);
    end
    release_keys();
    press_recall();
    checks++;
    if (bus.disp !== 8'h13 || bus.recall_active !== 1'b0) begin
      errors++;
      $display("FAIL cap_wrap: disp=%h ra=%b want 13 0",
               bus.disp, bus.recall_active);
    end
    release_keys();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 6; i++) capture(8'(i));
    checks++;
    if (bus.count !== 3'd4 || bus.q !== 8'h06 || bus.disp !== 8'h06) begin
      errors++;
      $display("FAIL sat: cnt=%0d q=%h disp=%h want 4 06 06",
               bus.count, bus.q, bus.disp);
    end
  endtask

  task automatic test_recall_cycle();
    logic [7:0] exp_d [5];
    logic       exp_a [5];
    exp_d = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h06};
    exp_a = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      press_recall();
      checks++;
      if (bus.disp !== exp_d[i] || bus.recall_active !== exp_a[i]) begin
        errors++;
        $display("FAIL recall[%0d]: disp=%h ra=%b want %h %b",
                 i, bus.disp, bus.recall_active, exp_d[i], exp_a[i]);
      end
      release_keys();
    end
  endtask

  task automatic test_empty_recall();
    do_reset();
    press_recall();
    checks++;
    if (bus.recall_active !== 1'b0 || bus.disp !== 8'h00) begin
      errors++;
      $display("FAIL empty_recall: ra=%b disp=%h want 0 00",
               bus.recall_active, bus.disp);
    end
    release_keys();
  endtask

  task automatic test_timeout();
    int hi;
    capture(8'hA7);
    capture(8'h5C);
    press_recall();
    hi = 0;
    if (bus.recall_active === 1'b1) hi = 1;
    @(negedge clk);
    bus.recall = 1'b0;
    for (int c = 0; c < 100 && bus.recall_active === 1'b1; c++) begin
      @(posedge clk);
      #1;
      if (bus.recall_active === 1'b1) hi++;
    end
    checks++;
    if (hi !== TMO) begin
      errors++;
      $display("FAIL timeout_len: cycles=%0d want %0d", hi, TMO);
    end
    checks++;
    if (bus.disp !== 8'h5C || bus.recall_active !== 1'b0) begin
      errors++;
      $display("FAIL timeout_live: disp=%h ra=%b want 5c 0",
               bus.disp, bus.recall_active);
    end
    release_keys();
  endtask

  task automatic test_collision();
    do_reset();
    capture(8'h21);
    @(negedge clk);
    bus.alu_in = 8'h42;
    bus.load = 1'b1;
    bus.recall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.q !== 8'h42 || bus.recall_active !== 1'b0 ||
        bus.count !== 3'd2 || bus.disp !== 8'h42) begin
      errors++;
      $display("FAIL collision: q=%h ra=%b cnt=%0d disp=%h want 42 0 2 42",
               bus.q, bus.recall_active, bus.count, bus.disp);
    end
    release_keys();
  endtask

  task automatic test_held_load();
    press_load(8'h77, 3'b011);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bus.alu_in = 8'(c + 8'h80);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.q !== 8'h77 || bus.count !== 3'd3) begin
      errors++;
      $display("FAIL held_load: q=%h cnt=%0d want 77 3", bus.q, bus.count);
    end
    release_keys();
  endtask

  task automatic test_ovf_reset();
    logic exp_ovf;
`ifdef ALU_RESULT_STAGE_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    do_reset();
    press_load(8'h1E, 3'b001);
    release_keys();
    checks++;
    if (bus.ovf !== exp_ovf || bus.q !== 8'h1E) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b q=%h want %b 1e", bus.ovf, bus.q, exp_ovf);
    end
    press_load(8'h10, 3'b011);
    release_keys();
    checks++;
    if (bus.ovf !== exp_ovf || bus.q !== 8'h10) begin
      errors++;
      $display("FAIL ovf_keep: ovf=%b q=%h want %b 10", bus.ovf, bus.q, exp_ovf);
    end
    press_recall();
    checks++;
    if (bus.recall_active !== 1'b1 || bus.disp !== 8'h1E) begin
      errors++;
      $display("FAIL pre_reset_recall: ra=%b disp=%h want 1 1e",
               bus.recall_active, bus.disp);
    end
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.q !== 8'h00 || bus.disp !== 8'h00 || bus.b_fb !== 4'h0 ||
        bus.recall_active !== 1'b0 || bus.count !== 3'd0 ||
        bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: q=%h disp=%h b_fb=%h ra=%b cnt=%0d ovf=%b",
               bus.q, bus.disp, bus.b_fb, bus.recall_active, bus.count, bus.ovf);
    end
    @(negedge clk);
    bus.recall = 1'b0;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.alu_in = '0;
    bus.func = '0;
    bus.load = 1'b0;
    bus.recall = 1'b0;
    test_reset();
    test_basic_capture();
    test_saturation();
    test_recall_cycle();
    test_empty_recall();
    test_timeout();
    test_collision();
    test_held_load();
    test_ovf_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
